// File: rtl/mips_pipeline_cpu.sv
// mips_pipeline_cpu: five-stage MIPS subset core with forwarding, hazard stalls and debug taps; define TRACE_EN for write tracing
module mips_pipeline_cpu #(
  parameter string IM_FILE = "code.txt",
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] npc,
  output logic [31:0] bjnpc,
  output logic        pcsel,
  output logic [1:0]  npcctrl,
  output logic        sta,
  output logic [5:0]  opd,
  output logic [4:0]  a1d,
  output logic [4:0]  a2d,
  output logic [31:0] qad,
  output logic [31:0] qbd,
  output logic [1:0]  fcmp1d,
  output logic [1:0]  fcmp2d,
  output logic [4:0]  a1e,
  output logic [4:0]  a2e,
  output logic [4:0]  a3e,
  output logic [1:0]  faluae,
  output logic [1:0]  falube,
  output logic [31:0] alua,
  output logic [31:0] alub,
  output logic [31:0] alu_c,
  output logic [4:0]  a3m,
  output logic [31:0] alu_out,
  output logic [31:0] dm_out,
  output logic [4:0]  a3w,
  output logic        regwritew
);
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ORI = 6'h0d,
                         OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23;
  logic [31:0] im [1024];
  logic [31:0] dm [1024];
  logic [31:0] rf [32];
  logic [31:0] ir_d, pc_d, ir_e, pc_e, qa_e, qb_e, alub_r, wd_m, alu_w, dm_w, wdata;
  logic [5:0]  op_e;
  logic        ld_m, st_m, ld_w, br_d, taken;

  function automatic logic is_r(input logic [31:0] ir, input logic [5:0] fn);
    return ir[31:26] == 6'h00 && ir[5:0] == fn;
  endfunction

  function automatic logic [4:0] dest(input logic [31:0] ir);
    return (is_r(ir, F_ADDU) || is_r(ir, F_SUBU)) ? ir[15:11] :
           (ir[31:26] inside {OP_ORI, OP_LUI, OP_LW}) ? ir[20:16] :
           ir[31:26] == OP_JAL ? 5'd31 : 5'd0;
  endfunction

  function automatic logic uses_rs(input logic [31:0] ir);
    return is_r(ir, F_ADDU) || is_r(ir, F_SUBU) || is_r(ir, F_JR) ||
           ir[31:26] inside {OP_ORI, OP_LW, OP_SW, OP_BEQ};
  endfunction

  function automatic logic uses_rt(input logic [31:0] ir);
    return is_r(ir, F_ADDU) || is_r(ir, F_SUBU) || ir[31:26] inside {OP_SW, OP_BEQ};
  endfunction

  function automatic logic hits(input logic [31:0] ir, input logic [4:0] a);
    return a != 5'd0 && ((uses_rs(ir) && ir[25:21] == a) || (uses_rt(ir) && ir[20:16] == a));
  endfunction

  // M wins over W; a load sitting in M has no data yet, so it is never a source
  function automatic logic [1:0] fsel(input logic [4:0] a, am, input logic lm, input logic [4:0] aw);
    return (a != 5'd0 && a == am && !lm) ? 2'b01 : (a != 5'd0 && a == aw) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] fmux(input logic [1:0] s, input logic [31:0] r, m, w);
    return s == 2'b01 ? m : s == 2'b10 ? w : r;
  endfunction

  assign inst = im[10'((pc - RESET_PC) >> 2)];
  assign npc = pc + 32'd4;

  assign opd = ir_d[31:26];
  assign a1d = ir_d[25:21];
  assign a2d = ir_d[20:16];
  assign fcmp1d = fsel(a1d, a3m, ld_m, a3w);
  assign fcmp2d = fsel(a2d, a3m, ld_m, a3w);
  assign qad = fmux(fcmp1d, rf[a1d], alu_out, wdata);
  assign qbd = fmux(fcmp2d, rf[a2d], alu_out, wdata);
  assign npcctrl = opd == OP_BEQ ? 2'b01 : opd inside {OP_J, OP_JAL} ? 2'b10 :
                   is_r(ir_d, F_JR) ? 2'b11 : 2'b00;
  assign bjnpc = npcctrl == 2'b10 ? {pc_d[31:28], ir_d[25:0], 2'b00} :
                 npcctrl == 2'b11 ? qad : pc_d + 32'd4 + {{14{ir_d[15]}}, ir_d[15:0], 2'b00};
  assign taken = npcctrl == 2'b01 ? qad == qbd : npcctrl != 2'b00;
  assign br_d = npcctrl == 2'b01 || npcctrl == 2'b11;
  // load-use hazard, branch on an E result, or branch on a load still in M
  assign sta = ((op_e == OP_LW || br_d) && hits(ir_d, a3e)) || (br_d && ld_m && hits(ir_d, a3m));
  assign pcsel = taken && !sta;

  assign op_e = ir_e[31:26];
  assign a1e = ir_e[25:21];
  assign a2e = ir_e[20:16];
  assign a3e = dest(ir_e);
  assign faluae = fsel(a1e, a3m, ld_m, a3w);
  assign falube = fsel(a2e, a3m, ld_m, a3w);
  assign alua = fmux(faluae, qa_e, alu_out, wdata);
  assign alub_r = fmux(falube, qb_e, alu_out, wdata);
  assign alub = op_e inside {OP_ORI, OP_LUI} ? {16'h0, ir_e[15:0]} :
                op_e inside {OP_LW, OP_SW} ? {{16{ir_e[15]}}, ir_e[15:0]} : alub_r;

  // ALU; jal rides the result path with its link address
  always_comb
    alu_c = is_r(ir_e, F_ADDU) ? alua + alub :
            is_r(ir_e, F_SUBU) ? alua - alub :
            op_e == OP_ORI ? (alua | alub) :
            op_e == OP_LUI ? {alub[15:0], 16'h0} :
            op_e inside {OP_LW, OP_SW} ? alua + alub :
            op_e == OP_JAL ? pc_e + 32'd8 : 32'h0;

  assign dm_out = dm[alu_out[11:2]];
  assign regwritew = a3w != 5'd0;
  assign wdata = ld_w ? dm_w : alu_w;

  // PC and F/D latch hold on stall; the delay-slot instruction always moves on
  always_ff @(posedge clk)
    if (!reset) begin
      pc <= RESET_PC;
      ir_d <= '0;
      pc_d <= '0;
    end else if (!sta) begin
      pc <= pcsel ? bjnpc : npc;
      ir_d <= inst;
      pc_d <= pc;
    end

  // D/E latch takes a bubble on stall
  always_ff @(posedge clk)
    if (!reset || sta) begin
      ir_e <= '0;
      pc_e <= '0;
      qa_e <= '0;
      qb_e <= '0;
    end else begin
      ir_e <= ir_d;
      pc_e <= pc_d;
      qa_e <= qad;
      qb_e <= qbd;
    end

  // E/M latch
  always_ff @(posedge clk)
    if (!reset) begin
      a3m <= '0;
      alu_out <= '0;
      wd_m <= '0;
      ld_m <= 1'b0;
      st_m <= 1'b0;
    end else begin
      a3m <= a3e;
      alu_out <= alu_c;
      wd_m <= alub_r;
      ld_m <= op_e == OP_LW;
      st_m <= op_e == OP_SW;
    end

  // M/W latch
  always_ff @(posedge clk)
    if (!reset) begin
      a3w <= '0;
      alu_w <= '0;
      dm_w <= '0;
      ld_w <= 1'b0;
    end else begin
      a3w <= a3m;
      alu_w <= alu_out;
      dm_w <= dm_out;
      ld_w <= ld_m;
    end

  // register file write in W; $0 is never a destination so it stays zero
  always_ff @(posedge clk)
    if (!reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (regwritew) rf[a3w] <= wdata;

  // data memory store in M
  always_ff @(posedge clk)
    if (!reset) for (int i = 0; i < 1024; i++) dm[i] <= '0;
    else if (st_m) dm[alu_out[11:2]] <= wd_m;

`ifdef TRACE_EN
  logic [31:0] pc_m, pc_w;
  // carry PCs to M/W and log register and memory writes
  always_ff @(posedge clk) begin
    pc_m <= !reset ? '0 : pc_e;
    pc_w <= !reset ? '0 : pc_m;
    if (reset && regwritew) $display("@%h: $%d <= %h", pc_w, a3w, wdata);
    if (reset && st_m) $display("@%h: *%h <= %h", pc_m, alu_out, wd_m);
  end
`endif
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// tb_mips_pipeline_cpu: directed pipeline checks plus random programs against an ISA-level model
module tb_mips_pipeline_cpu;
  localparam int OP_J = 'h02, OP_JAL = 'h03, OP_BEQ = 'h04, OP_ORI = 'h0d, OP_LUI = 'h0f,
                 OP_LW = 'h23, OP_SW = 'h2b;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc, inst, npc, bjnpc, qad, qbd, alua, alub, alu_c, alu_out, dm_out;
  logic pcsel, sta, regwritew;
  logic [1:0] npcctrl, fcmp1d, fcmp2d, faluae, falube;
  logic [5:0] opd;
  logic [4:0] a1d, a2d, a1e, a2e, a3e, a3m, a3w;
  logic [31:0] prog [1024];
  logic [31:0] regs [8];
  logic [31:0] mem [8];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mips_pipeline_cpu #(.IM_FILE(""), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst), .npc(npc), .bjnpc(bjnpc),
    .pcsel(pcsel), .npcctrl(npcctrl), .sta(sta), .opd(opd), .a1d(a1d), .a2d(a2d),
    .qad(qad), .qbd(qbd), .fcmp1d(fcmp1d), .fcmp2d(fcmp2d), .a1e(a1e), .a2e(a2e),
    .a3e(a3e), .faluae(faluae), .falube(falube), .alua(alua), .alub(alub),
    .alu_c(alu_c), .a3m(a3m), .alu_out(alu_out), .dm_out(dm_out), .a3w(a3w),
    .regwritew(regwritew)
  );

  function automatic logic [31:0] enc_r(input int s, t, d, f);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(f)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, s, t, imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, idx);
    return {6'(op), 26'(idx)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 1024; k++) prog[k] = 32'h0;
  endtask

  task automatic load();
    for (int k = 0; k < 1024; k++) dut.im[k] = prog[k];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    check("rst_pc", pc, 32'h3000);
    check("rst_regwritew", {31'd0, regwritew}, 32'd0);
    check("rst_sta", {31'd0, sta}, 32'd0);
    check("rst_pcsel", {31'd0, pcsel}, 32'd0);
    check("rst_a3e", {27'd0, a3e}, 32'd0);
    check("rst_a3w", {27'd0, a3w}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    int c, s, t, d, imm, off;
    logic [31:0] v;
    // forwarding from M and W into an addu
    clear_prog();
    prog[0] = enc_i(OP_ORI, 0, 1, 5);
    prog[1] = enc_i(OP_ORI, 0, 2, 7);
    prog[2] = enc_r(1, 2, 3, 'h21);
    load();
    do_reset();
    tick();
    check("a_pc1", pc, 32'h3004);
    tick();
    check("a_pc2", pc, 32'h3008);
    tick();
    check("a_fcmp1d", {30'd0, fcmp1d}, 32'd1);
    check("a_fcmp2d", {30'd0, fcmp2d}, 32'd0);
    tick();
    check("a_faluae", {30'd0, faluae}, 32'd2);
    check("a_falube", {30'd0, falube}, 32'd1);
    check("a_alua", alua, 32'd5);
    check("a_alub", alub, 32'd7);
    check("a_alu_c", alu_c, 32'hC);
    tick();
    tick();
    check("a_a3w", {27'd0, a3w}, 32'd3);
    check("a_regwritew", {31'd0, regwritew}, 32'd1);
    tick();
    check("a_rf3", dut.rf[3], 32'd12);
    // load-use stall then W forward
    clear_prog();
    prog[0] = enc_i(OP_ORI, 0, 8, 'h1234);
    prog[1] = enc_i(OP_SW, 0, 8, 0);
    prog[2] = enc_i(OP_LW, 0, 4, 0);
    prog[3] = enc_r(4, 4, 5, 'h21);
    load();
    do_reset();
    repeat (3) tick();
    check("b_sta_e3", {31'd0, sta}, 32'd0);
    check("b_sw_falube", {30'd0, falube}, 32'd1);
    tick();
    check("b_sta_e4", {31'd0, sta}, 32'd1);
    check("b_pc_e4", pc, 32'h3010);
    tick();
    check("b_sta_e5", {31'd0, sta}, 32'd0);
    check("b_pc_hold", pc, 32'h3010);
    check("b_dm_out", dm_out, 32'h1234);
    tick();
    check("b_faluae", {30'd0, faluae}, 32'd2);
    check("b_falube", {30'd0, falube}, 32'd2);
    check("b_alu_c", alu_c, 32'h2468);
    check("b_pc_e6", pc, 32'h3014);
    repeat (3) tick();
    check("b_rf4", dut.rf[4], 32'h1234);
    check("b_rf5", dut.rf[5], 32'h2468);
    // beq with branch stall and delay slot
    clear_prog();
    prog[0] = enc_i(OP_ORI, 0, 6, 3);
    prog[1] = enc_i(OP_BEQ, 6, 6, 2);
    prog[2] = enc_i(OP_ORI, 0, 9, 1);
    prog[3] = enc_i(OP_ORI, 0, 10, 1);
    prog[4] = enc_i(OP_ORI, 0, 11, 1);
    load();
    do_reset();
    repeat (2) tick();
    check("c_sta", {31'd0, sta}, 32'd1);
    check("c_pcsel_stalled", {31'd0, pcsel}, 32'd0);
    tick();
    check("c_sta_clear", {31'd0, sta}, 32'd0);
    check("c_pc_hold", pc, 32'h3008);
    check("c_fcmp1d", {30'd0, fcmp1d}, 32'd1);
    check("c_qbd", qbd, 32'd3);
    check("c_npcctrl", {30'd0, npcctrl}, 32'd1);
    check("c_pcsel", {31'd0, pcsel}, 32'd1);
    check("c_bjnpc", bjnpc, 32'h3010);
    tick();
    check("c_pc_target", pc, 32'h3010);
    check("c_slot_a2d", {27'd0, a2d}, 32'd9);
    repeat (8) tick();
    check("c_rf9", dut.rf[9], 32'd1);
    check("c_rf10", dut.rf[10], 32'd0);
    check("c_rf11", dut.rf[11], 32'd1);
    // jal / jr round trip
    clear_prog();
    prog[0] = enc_j(OP_JAL, 'hC40);
    prog[1] = enc_i(OP_ORI, 0, 12, 2);
    prog[2] = enc_i(OP_ORI, 0, 13, 3);
    prog[64] = enc_r(31, 0, 0, 'h08);
    prog[65] = enc_i(OP_ORI, 0, 14, 4);
    load();
    do_reset();
    tick();
    check("d_npcctrl_j", {30'd0, npcctrl}, 32'd2);
    check("d_pcsel_j", {31'd0, pcsel}, 32'd1);
    check("d_bjnpc_j", bjnpc, 32'h3100);
    tick();
    check("d_pc_jump", pc, 32'h3100);
    check("d_link", alu_c, 32'h3008);
    tick();
    check("d_sta_jr", {31'd0, sta}, 32'd0);
    check("d_npcctrl_jr", {30'd0, npcctrl}, 32'd3);
    check("d_fcmp1d_jr", {30'd0, fcmp1d}, 32'd1);
    check("d_bjnpc_jr", bjnpc, 32'h3008);
    tick();
    check("d_pc_return", pc, 32'h3008);
    repeat (10) tick();
    check("d_rf31", dut.rf[31], 32'h3008);
    check("d_rf12", dut.rf[12], 32'd2);
    check("d_rf13", dut.rf[13], 32'd3);
    check("d_rf14", dut.rf[14], 32'd4);
    // sw then lw of the same word, then reset mid-run
    clear_prog();
    prog[0] = enc_i(OP_ORI, 0, 3, 12);
    prog[1] = enc_i(OP_SW, 0, 3, 4);
    prog[2] = enc_i(OP_LW, 0, 7, 4);
    load();
    do_reset();
    repeat (5) tick();
    check("e_dm_out", dm_out, 32'hC);
    check("e_a3m", {27'd0, a3m}, 32'd7);
    repeat (3) tick();
    check("e_rf7", dut.rf[7], 32'd12);
    do_reset();
    check("e_rf7_cleared", dut.rf[7], 32'd0);
    check("e_dm1_cleared", dut.dm[1], 32'd0);
    // random straight-line programs against the ISA model
    for (int r = 0; r < 3; r++) begin
      clear_prog();
      for (int k = 0; k < 8; k++) begin
        regs[k] = 32'h0;
        mem[k] = 32'h0;
      end
      for (int k = 0; k < 40; k++) begin
        c = int'($urandom_range(0, 5));
        s = int'($urandom_range(0, 7));
        t = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 65535));
        off = int'($urandom_range(0, 7));
        if (c == 0) begin
          prog[k] = enc_r(s, t, d, 'h21);
          v = regs[s] + regs[t];
          if (d != 0) regs[d] = v;
        end else if (c == 1) begin
          prog[k] = enc_r(s, t, d, 'h23);
          v = regs[s] - regs[t];
          if (d != 0) regs[d] = v;
        end else if (c == 2) begin
          prog[k] = enc_i(OP_ORI, s, t, imm);
          v = regs[s] | 32'(imm);
          if (t != 0) regs[t] = v;
        end else if (c == 3) begin
          prog[k] = enc_i(OP_LUI, 0, t, imm);
          if (t != 0) regs[t] = 32'(imm) << 16;
        end else if (c == 4) begin
          prog[k] = enc_i(OP_LW, 0, t, off * 4);
          if (t != 0) regs[t] = mem[off];
        end else begin
          prog[k] = enc_i(OP_SW, 0, t, off * 4);
          mem[off] = regs[t];
        end
      end
      load();
      do_reset();
      repeat (120) tick();
      for (int k = 0; k < 8; k++) begin
        check($sformatf("rnd%0d_rf%0d", r, k), dut.rf[k], regs[k]);
        check($sformatf("rnd%0d_dm%0d", r, k), dut.dm[k], mem[k]);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
